// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module : multicycle_ctrl_fsm
// Multi-cycle MIPS main control FSM with memory handshake, watchdog, sticky trap.
// Rev    : 1.0  initial release
// ============================================================================
module multicycle_ctrl_fsm #(
   parameter int ALUOP_W    = 3,
   parameter int TIMEOUT    = 16,
   parameter bit ENABLE_EXT = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [5:0]         instr_op_i,
   input  logic               mem_ready_i,
   input  logic               alu_zero_i,
   output logic               pc_write_o,
   output logic               pc_write_c_o,
   output logic               ir_write_o,
   output logic               mem_req_o,
   output logic               mem_we_o,
   output logic               iord_o,
   output logic               reg_write_o,
   output logic [1:0]         reg_dst_o,
   output logic [1:0]         mem_to_reg_o,
   output logic [1:0]         alu_src_b_o,
   output logic               alu_src_a_o,
   output logic [ALUOP_W-1:0] alu_op_o,
   output logic [1:0]         branch_type_o,
   output logic               zero_ext_o,
   output logic               jump_o,
   output logic               trap_o,
   output logic [2:0]         state_o
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_FETCH  = 3'd1;
   localparam logic [2:0] c_DECODE = 3'd2;
   localparam logic [2:0] c_EXEC   = 3'd3;
   localparam logic [2:0] c_MEM    = 3'd4;
   localparam logic [2:0] c_WB     = 3'd5;
   localparam logic [2:0] c_TRAP   = 3'd6;

   localparam logic [5:0] c_OP_R     = 6'd0;
   localparam logic [5:0] c_OP_BLTZ  = 6'd1;
   localparam logic [5:0] c_OP_J     = 6'd2;
   localparam logic [5:0] c_OP_JAL   = 6'd3;
   localparam logic [5:0] c_OP_BEQ   = 6'd4;
   localparam logic [5:0] c_OP_BNE   = 6'd5;
   localparam logic [5:0] c_OP_BLE   = 6'd6;
   localparam logic [5:0] c_OP_ADDI  = 6'd8;
   localparam logic [5:0] c_OP_SLTIU = 6'd11;
   localparam logic [5:0] c_OP_ORI   = 6'd13;
   localparam logic [5:0] c_OP_LI    = 6'd15;
   localparam logic [5:0] c_OP_LW    = 6'd35;
   localparam logic [5:0] c_OP_SW    = 6'd43;

   localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [2:0]         r_state;
   logic [2:0]         w_nextState;
   logic [5:0]         r_opReg;
   logic [c_CNT_W-1:0] r_waitCnt;
   logic [5:0]         w_op;
   logic               w_legal;
   logic               w_isBranch;
   logic               w_waiting;
   logic               w_timeout;
   logic               w_unusedZero;

   // Branch resolution is done in the datapath; the controller only issues the conditional strobe.
   assign w_unusedZero = alu_zero_i;

   // The IR is already loaded during DECODE, so its opcode is used directly in that state.
   assign w_op       = (r_state == c_DECODE) ? instr_op_i : r_opReg;
   assign w_isBranch = (w_op == c_OP_BEQ) || (w_op == c_OP_BNE) ||
                       (w_op == c_OP_BLE) || (w_op == c_OP_BLTZ);
   assign w_waiting  = ((r_state == c_FETCH) || (r_state == c_MEM)) && !mem_ready_i;
   assign w_timeout  = (TIMEOUT != 0) && w_waiting &&
                       (r_waitCnt == c_CNT_W'(TIMEOUT - 1));
   assign state_o    = r_state;

   always_comb begin
      w_legal = 1'b0;
      case (instr_op_i)
         c_OP_R, c_OP_J, c_OP_JAL, c_OP_BEQ, c_OP_BNE, c_OP_ADDI,
         c_OP_SLTIU, c_OP_ORI, c_OP_LW, c_OP_SW: w_legal = 1'b1;
         c_OP_BLE, c_OP_BLTZ, c_OP_LI:            w_legal = ENABLE_EXT;
         default:                                 w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_opReg   <= 6'd0;
         r_waitCnt <= '0;
      end else begin
         if (r_state == c_DECODE) begin
            r_opReg <= instr_op_i;
         end
         // Counter is zero whenever a wait state is entered because it clears outside them.
         r_waitCnt <= w_waiting ? (r_waitCnt + c_CNT_W'(1)) : '0;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_IDLE:   w_nextState = c_FETCH;
         c_FETCH: begin
            if (mem_ready_i)    w_nextState = c_DECODE;
            else if (w_timeout) w_nextState = c_TRAP;
         end
         c_DECODE: begin
            if (!w_legal)            w_nextState = c_TRAP;
            else if (w_op == c_OP_J)   w_nextState = c_FETCH;
            else if (w_op == c_OP_JAL) w_nextState = c_WB;
            else                       w_nextState = c_EXEC;
         end
         c_EXEC: begin
            if (w_isBranch)                             w_nextState = c_FETCH;
            else if ((w_op == c_OP_LW) || (w_op == c_OP_SW)) w_nextState = c_MEM;
            else                                        w_nextState = c_WB;
         end
         c_MEM: begin
            if (mem_ready_i)    w_nextState = (r_opReg == c_OP_LW) ? c_WB : c_FETCH;
            else if (w_timeout) w_nextState = c_TRAP;
         end
         c_WB:     w_nextState = c_FETCH;
         c_TRAP:   w_nextState = c_TRAP;
         default:  w_nextState = c_TRAP;
      endcase
   end

   always_comb begin
      pc_write_o    = 1'b0;
      pc_write_c_o  = 1'b0;
      ir_write_o    = 1'b0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      iord_o        = 1'b0;
      reg_write_o   = 1'b0;
      reg_dst_o     = 2'b00;
      mem_to_reg_o  = 2'b00;
      alu_src_b_o   = 2'b00;
      alu_src_a_o   = 1'b0;
      alu_op_o      = '0;
      branch_type_o = 2'b00;
      zero_ext_o    = 1'b0;
      jump_o        = 1'b0;
      trap_o        = 1'b0;
      case (r_state)
         c_FETCH: begin
            mem_req_o   = 1'b1;
            alu_src_b_o = 2'b01;
            alu_op_o    = ALUOP_W'(3'b010);
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         c_DECODE: begin
            alu_src_b_o = 2'b11;
            alu_op_o    = ALUOP_W'(3'b010);
            if ((w_op == c_OP_J) || (w_op == c_OP_JAL)) begin
               pc_write_o = 1'b1;
               jump_o     = 1'b1;
            end
         end
         c_EXEC: begin
            alu_src_a_o  = 1'b1;
            alu_src_b_o  = (w_op == c_OP_R) ? 2'b00 : 2'b10;
            zero_ext_o   = (w_op == c_OP_ORI);
            pc_write_c_o = w_isBranch;
            case (w_op)
               c_OP_BEQ:                         alu_op_o = ALUOP_W'(3'b001);
               c_OP_BLE:  begin alu_op_o = ALUOP_W'(3'b001); branch_type_o = 2'b01; end
               c_OP_BLTZ: begin alu_op_o = ALUOP_W'(3'b001); branch_type_o = 2'b10; end
               c_OP_BNE:  begin alu_op_o = ALUOP_W'(3'b110); branch_type_o = 2'b11; end
               c_OP_ADDI, c_OP_LW, c_OP_SW, c_OP_LI: alu_op_o = ALUOP_W'(3'b010);
               c_OP_SLTIU:                       alu_op_o = ALUOP_W'(3'b011);
               c_OP_ORI:                         alu_op_o = ALUOP_W'(3'b101);
               default:                          alu_op_o = ALUOP_W'(3'b000);
            endcase
         end
         c_MEM: begin
            mem_req_o = 1'b1;
            iord_o    = 1'b1;
            mem_we_o  = (r_opReg == c_OP_SW);
         end
         c_WB: begin
            reg_write_o = 1'b1;
            case (w_op)
               c_OP_R:   reg_dst_o = 2'b01;
               c_OP_LW:  mem_to_reg_o = 2'b01;
               c_OP_JAL: begin reg_dst_o = 2'b10; mem_to_reg_o = 2'b10; end
               default:  reg_dst_o = 2'b00;
            endcase
         end
         c_TRAP:   trap_o = 1'b1;
         default:  trap_o = 1'b0;
      endcase
   end

endmodule
`default_nettype wire
